// File: rtl/sp_pkg.sv
// Shared types and constants for the stack-pointer unit.
// Holds state encoding, direction constants and the count-width helper.
package sp_pkg;

    typedef enum logic {
        SP_IDLE  = 1'b0,
        SP_BURST = 1'b1
    } sp_state_t;

    localparam logic SP_DIR_PUSH = 1'b1;
    localparam logic SP_DIR_POP  = 1'b0;

    function automatic int sp_cnt_w(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/sp_unit_bound_check.sv
// Combinational acceptance check for push/pop requests.
// Extra top bit keeps the limit arithmetic free of wrap-around.
module sp_bound_check
    import sp_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] SP_RESET  = 32'h0000_0FFF,
    parameter logic [ADDR_W-1:0] SP_LIMIT  = 32'h0000_0FF0,
    parameter int                MAX_WORDS = 4,
    parameter int                CNT_W     = sp_cnt_w(MAX_WORDS)
) (
    input  logic [ADDR_W-1:0] sp,
    input  logic              dir,
    input  logic [CNT_W-1:0]  count,
    output logic              ok
);

    logic [ADDR_W:0] sp_x;
    logic [ADDR_W:0] cnt_x;
    logic [ADDR_W:0] one_x;
    logic            fits;
    logic            room;

    // Push: lowest written word sp-count+1 stays at or above the limit,
    // rearranged as sp+1 >= limit+count so nothing can underflow.
    // Pop: highest read word sp+count stays at or below the stack top.
    always_comb begin
        sp_x  = {1'b0, sp};
        cnt_x = '0;
        cnt_x[CNT_W-1:0] = count;
        one_x = '0;
        one_x[0] = 1'b1;
        fits  = (count <= CNT_W'(MAX_WORDS));
        if (dir == SP_DIR_PUSH) begin
            room = (sp_x + one_x) >= ({1'b0, SP_LIMIT} + cnt_x);
        end else begin
            room = (sp_x + cnt_x) <= {1'b0, SP_RESET};
        end
        ok = fits && room;
    end

endmodule

// File: rtl/sp_unit.sv
// Stack-pointer unit: splits push/pop requests into single-word beats.
// Define SP_FAULT_EN to enable bound and count checks with a fault pulse.
module sp_unit
    import sp_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] SP_RESET  = 32'h0000_0FFF,
    parameter logic [ADDR_W-1:0] SP_LIMIT  = 32'h0000_0FF0,
    parameter int                MAX_WORDS = 4,
    parameter int                CNT_W     = sp_cnt_w(MAX_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              op_push,
    input  logic [CNT_W-1:0]  op_count,
    output logic              op_ready,
    output logic              mem_valid,
    output logic              mem_push,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              flush,
    input  logic              sp_load,
    input  logic [ADDR_W-1:0] sp_wdata,
    output logic [ADDR_W-1:0] sp,
    output logic              busy,
    output logic              fault
);

    sp_state_t         state_q;
    sp_state_t         state_d;
    logic [ADDR_W-1:0] sp_q;
    logic              dir_q;
    logic [CNT_W-1:0]  rem_q;
    logic              fault_q;
    logic              accept;
    logic              beat;
    logic              req_ok;
    logic [CNT_W-1:0]  cnt_eff;

`ifdef SP_FAULT_EN
    logic check_ok;

    sp_bound_check #(
        .ADDR_W    (ADDR_W),
        .SP_RESET  (SP_RESET),
        .SP_LIMIT  (SP_LIMIT),
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W)
    ) u_check (
        .sp    (sp_q),
        .dir   (op_push),
        .count (op_count),
        .ok    (check_ok)
    );

    assign req_ok  = check_ok;
    assign cnt_eff = op_count;
`else
    assign req_ok  = 1'b1;
    assign cnt_eff = (op_count > CNT_W'(MAX_WORDS)) ?
                     CNT_W'(MAX_WORDS) : op_count;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and beat presentation.
    always_comb begin
        state_d   = state_q;
        op_ready  = 1'b0;
        accept    = 1'b0;
        beat      = 1'b0;
        busy      = 1'b0;
        mem_valid = 1'b0;
        mem_push  = 1'b0;
        mem_addr  = sp_q;
        unique case (state_q)
            SP_IDLE: begin
                op_ready = !sp_load;
                accept   = op_valid && !sp_load;
                if (accept && req_ok && (cnt_eff != '0)) begin
                    state_d = SP_BURST;
                end
            end
            SP_BURST: begin
                busy      = 1'b1;
                mem_valid = 1'b1;
                mem_push  = dir_q;
                mem_addr  = (dir_q == SP_DIR_PUSH) ?
                            sp_q : sp_q + ADDR_W'(1);
                beat      = mem_ready;
                if (flush) begin
                    state_d = SP_IDLE;
                end else if (beat && (rem_q == CNT_W'(1))) begin
                    state_d = SP_IDLE;
                end
            end
            default: state_d = SP_IDLE;
        endcase
    end

    // SP, direction, remaining count and the registered fault pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= SP_RESET;
            dir_q   <= SP_DIR_POP;
            rem_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= accept && !req_ok;
            if (state_q == SP_IDLE) begin
                if (sp_load) begin
                    sp_q <= sp_wdata;
                end else if (accept && req_ok) begin
                    dir_q <= op_push;
                    rem_q <= cnt_eff;
                end
            end else if (beat && !flush) begin
                sp_q  <= (dir_q == SP_DIR_PUSH) ?
                         sp_q - ADDR_W'(1) : sp_q + ADDR_W'(1);
                rem_q <= rem_q - CNT_W'(1);
            end
        end
    end

    assign sp    = sp_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_sp_unit.sv
// Self-checking bench for sp_unit: request table plus directed
// sequences for stall/flush, sp_load priority and mid-burst reset.
module tb_sp_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_push;
    logic [2:0]  op_count;
    logic        op_ready;
    logic        mem_valid;
    logic        mem_push;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        flush;
    logic        sp_load;
    logic [31:0] sp_wdata;
    logic [31:0] sp;
    logic        busy;
    logic        fault;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sp_unit dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_push   (op_push),
        .op_count  (op_count),
        .op_ready  (op_ready),
        .mem_valid (mem_valid),
        .mem_push  (mem_push),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .flush     (flush),
        .sp_load   (sp_load),
        .sp_wdata  (sp_wdata),
        .sp        (sp),
        .busy      (busy),
        .fault     (fault)
    );

    typedef struct {
        logic        push;
        logic [2:0]  count;
        logic        exp_fault;
        int          exp_beats;
        logic [31:0] exp_first;
        logic [31:0] exp_sp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic p, input int c, input logic f,
                                input int b, input logic [31:0] first,
                                input logic [31:0] spv);
        vec_t v;
        v.push      = p;
        v.count     = 3'(c);
        v.exp_fault = f;
        v.exp_beats = b;
        v.exp_first = first;
        v.exp_sp    = spv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic p, input logic [2:0] c,
                          input logic [31:0] first, output int beats,
                          output int addr_err, output int dir_err,
                          output logic saw_fault, output int cyc);
        logic [31:0] exp_a;
        op_valid = 1'b1;
        op_push  = p;
        op_count = c;
        tick();
        op_valid  = 1'b0;
        beats     = 0;
        addr_err  = 0;
        dir_err   = 0;
        saw_fault = fault;
        cyc       = 1;
        while (!op_ready && cyc < 20) begin
            if (mem_valid && mem_ready) begin
                exp_a = p ? first - 32'(beats) : first + 32'(beats);
                if (mem_addr !== exp_a) addr_err++;
                if (mem_push !== p) dir_err++;
                beats++;
            end
            tick();
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          beats;
        int          aerr;
        int          derr;
        logic        sf;
        int          cyc;

`ifdef SP_FAULT_EN
        vecs.push_back(mk(1, 2, 0, 2, 32'hFFF, 32'hFFD));
        vecs.push_back(mk(0, 2, 0, 2, 32'hFFE, 32'hFFF));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,   32'hFFF));
        vecs.push_back(mk(1, 4, 0, 4, 32'hFFF, 32'hFFB));
        vecs.push_back(mk(1, 4, 0, 4, 32'hFFB, 32'hFF7));
        vecs.push_back(mk(1, 4, 0, 4, 32'hFF7, 32'hFF3));
        vecs.push_back(mk(1, 4, 0, 4, 32'hFF3, 32'hFEF));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,   32'hFEF));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'hFEF));
        vecs.push_back(mk(0, 4, 0, 4, 32'hFF0, 32'hFF3));
        vecs.push_back(mk(1, 5, 1, 0, 32'h0,   32'hFF3));
`else
        vecs.push_back(mk(1, 2, 0, 2, 32'hFFF, 32'hFFD));
        vecs.push_back(mk(0, 2, 0, 2, 32'hFFE, 32'hFFF));
        vecs.push_back(mk(1, 4, 0, 4, 32'hFFF, 32'hFFB));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'hFFB));
        vecs.push_back(mk(1, 7, 0, 4, 32'hFFB, 32'hFF7));
        vecs.push_back(mk(0, 4, 0, 4, 32'hFF8, 32'hFFB));
        vecs.push_back(mk(0, 4, 0, 4, 32'hFFC, 32'hFFF));
`endif

        rst       = 1'b1;
        op_valid  = 1'b0;
        op_push   = 1'b0;
        op_count  = '0;
        mem_ready = 1'b1;
        flush     = 1'b0;
        sp_load   = 1'b0;
        sp_wdata  = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset sp", sp, 32'hFFF);
        chk("reset busy", 32'(busy), 0);
        chk("reset op_ready", 32'(op_ready), 1);
        chk("reset mem_valid", 32'(mem_valid), 0);
        chk("reset mem_push", 32'(mem_push), 0);
        chk("reset mem_addr", mem_addr, 32'hFFF);
        chk("reset fault", 32'(fault), 0);

        foreach (vecs[i]) begin
            do_req(vecs[i].push, vecs[i].count, vecs[i].exp_first,
                   beats, aerr, derr, sf, cyc);
            chk($sformatf("v%0d fault", i), 32'(sf),
                32'(vecs[i].exp_fault));
            chk($sformatf("v%0d cycles", i), 32'(cyc),
                32'(vecs[i].exp_beats + 1));
            chk($sformatf("v%0d beats", i), 32'(beats),
                32'(vecs[i].exp_beats));
            if (vecs[i].exp_beats > 0) begin
                chk($sformatf("v%0d addr errs", i), 32'(aerr), 0);
                chk($sformatf("v%0d dir errs", i), 32'(derr), 0);
            end
            chk($sformatf("v%0d sp", i), sp, vecs[i].exp_sp);
            tick();
            chk($sformatf("v%0d fault clear", i), 32'(fault), 0);
        end

        // Stall on beat 1, then flush while beat 2 completes.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;
        op_valid  = 1'b1;
        op_push   = 1'b1;
        op_count  = 3'd3;
        tick();
        op_valid = 1'b0;
        chk("stall valid", 32'(mem_valid), 1);
        chk("stall addr0", mem_addr, 32'hFFF);
        chk("stall push", 32'(mem_push), 1);
        tick();
        chk("stall addr1", mem_addr, 32'hFFF);
        chk("stall sp", sp, 32'hFFF);
        mem_ready = 1'b1;
        tick();
        chk("beat2 addr", mem_addr, 32'hFFE);
        chk("beat1 sp", sp, 32'hFFE);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush sp", sp, 32'hFFE);
        chk("flush busy", 32'(busy), 0);
        chk("flush mem_valid", 32'(mem_valid), 0);
        chk("flush op_ready", 32'(op_ready), 1);

        // sp_load beats a simultaneous request; ignored mid-burst.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        sp_load  = 1'b1;
        sp_wdata = 32'h800;
        op_valid = 1'b1;
        op_push  = 1'b1;
        op_count = 3'd1;
        #1;
        chk("load blocks ready", 32'(op_ready), 0);
        tick();
        sp_load  = 1'b0;
        op_valid = 1'b0;
        chk("load sp", sp, 32'h800);
        chk("load no burst", 32'(busy), 0);
        sp_load  = 1'b1;
        sp_wdata = 32'hFFA;
        tick();
        sp_load  = 1'b0;
        op_valid = 1'b1;
        op_push  = 1'b1;
        op_count = 3'd3;
        tick();
        op_valid = 1'b0;
        sp_load  = 1'b1;
        sp_wdata = 32'h123;
        tick();
        sp_load = 1'b0;
        chk("burst load ignored", sp, 32'hFF9);
        chk("burst busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst sp", sp, 32'hFFF);
        chk("mid rst mem_valid", 32'(mem_valid), 0);
        chk("mid rst busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
